led_point_scanner: RTL

//  Receiver end of the game's 10-bit LED point bus. Collects the time-multiplexed point words
//  (one lit dot per word) into a double-buffered 16-row x 32-column frame buffer and drives
//  the dot-matrix as a row-scanned display. Sits between the game core's LEDout and the pins.

---
 rtl/led_point_scanner.sv | 93 +++++++++
 1 files changed

// File: rtl/led_point_scanner.sv
// Purpose: collects 10-bit LED point words into a double-buffered 16x32 frame and row-scans it out.
// Latency: col_data follows row/front changes by one CLK; all outputs registered. No backpressure: pt_in sampled every CLK.
// Optional BLANK_GAP_EN: darkens the first BLANK_CYCLES of every row dwell.
module led_point_scanner #(
    parameter logic [21:0] ROW_CYCLES   = 22'd2000,
    parameter logic [21:0] ACC_CYCLES   = 22'd262144,
    parameter logic [21:0] BLANK_CYCLES = 22'd100
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [9:0]  pt_in,
    output logic [3:0]  row_addr,
    output logic [31:0] col_data,
    output logic        row_en,
    output logic        frame_swap
);

    logic [15:0][31:0] front_q, front_d;
    logic [15:0][31:0] back_q,  back_d;
    logic [21:0]       acc_q,   acc_d;
    logic [21:0]       dwell_q, dwell_d;
    logic [3:0]        row_q,   row_d;
    logic              pend_q,  pend_d;
    logic [31:0]       col_q,   col_d;
    logic              row_en_q, row_en_d;
    logic              swap_q;

    logic acc_wrap;
    logic dwell_wrap;
    logic swap_w;
    logic in_gap;

    always_comb begin
        acc_wrap   = (acc_q == ACC_CYCLES - 22'd1);
        dwell_wrap = (dwell_q == ROW_CYCLES - 22'd1);
        swap_w     = dwell_wrap && (row_q == 4'd15) && pend_q;

        acc_d   = acc_wrap   ? 22'd0 : acc_q + 22'd1;
        dwell_d = dwell_wrap ? 22'd0 : dwell_q + 22'd1;
        row_d   = dwell_wrap ? row_q + 4'd1 : row_q;

        // A swap consumes the pending request even if a new window closes on the same cycle.
        if (swap_w)
            pend_d = 1'b0;
        else if (acc_wrap)
            pend_d = 1'b1;
        else
            pend_d = pend_q;

        front_d = swap_w ? back_q : front_q;
        back_d  = swap_w ? '0     : back_q;
        if (!pt_in[9])
            back_d[pt_in[3:0]][{pt_in[8], pt_in[7:4]}] = 1'b1;

`ifdef BLANK_GAP_EN
        in_gap = (dwell_d < BLANK_CYCLES);
`else
        in_gap = 1'b0;
`endif
        row_en_d = !in_gap;
        col_d    = in_gap ? 32'd0 : front_q[row_q];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            front_q  <= '0;
            back_q   <= '0;
            acc_q    <= 22'd0;
            dwell_q  <= 22'd0;
            row_q    <= 4'd0;
            pend_q   <= 1'b0;
            col_q    <= 32'd0;
            row_en_q <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            front_q  <= front_d;
            back_q   <= back_d;
            acc_q    <= acc_d;
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            pend_q   <= pend_d;
            col_q    <= col_d;
            row_en_q <= row_en_d;
            swap_q   <= swap_w;
        end
    end

    assign row_addr   = row_q;
    assign col_data   = col_q;
    assign row_en     = row_en_q;
    assign frame_swap = swap_q;

endmodule
